pipe_skid_reg: RTL and testbench

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

---
 rtl/pipe_skid_reg.sv | 137 +++++++++++++
 tb/tb_pipe_skid_reg.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_reg.sv
// Two-entry pipeline skid register (MAIN + SKID) with registered in_ready_o.
// Optional output stall counter enabled by defining PIPE_SKID_STALL_CNT_EN.
module pipe_skid_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PC_W   = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [PC_W-1:0]   pc_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [PC_W-1:0]   pc_o,
  output logic [DATA_W-1:0] data_o,
  output logic [1:0]        occ_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   main_pc_q, main_pc_d, skid_pc_q, skid_pc_d;
  logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic              in_ready_q, in_ready_d;
  logic              in_acc, out_acc;

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = (state_q != StEmpty);
  assign pc_o        = main_pc_q;
  assign data_o      = main_data_q;
  assign in_acc      = in_valid_i & in_ready_q;
  assign out_acc     = out_valid_o & out_ready_i;

  always_comb begin
    occ_o = 2'd0;
    unique case (state_q)
      StEmpty: occ_o = 2'd0;
      StOne:   occ_o = 2'd1;
      StTwo:   occ_o = 2'd2;
      default: occ_o = 2'd0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    main_pc_d   = main_pc_q;
    main_data_d = main_data_q;
    skid_pc_d   = skid_pc_q;
    skid_data_d = skid_data_q;
    if (flush_i) begin
      state_d     = StEmpty;
      main_pc_d   = '0;
      main_data_d = '0;
      skid_pc_d   = '0;
      skid_data_d = '0;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (in_acc) begin
            main_pc_d   = pc_i;
            main_data_d = data_i;
            state_d     = StOne;
          end
        end
        StOne: begin
          if (in_acc && out_acc) begin
            main_pc_d   = pc_i;
            main_data_d = data_i;
          end else if (in_acc) begin
            skid_pc_d   = pc_i;
            skid_data_d = data_i;
            state_d     = StTwo;
          end else if (out_acc) begin
            // MAIN keeps its last value so pc_o/data_o hold while empty.
            state_d = StEmpty;
          end
        end
        StTwo: begin
          if (out_acc) begin
            main_pc_d   = skid_pc_q;
            main_data_d = skid_data_q;
            state_d     = StOne;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
    in_ready_d = (state_d != StTwo);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StEmpty;
      main_pc_q   <= '0;
      main_data_q <= '0;
      skid_pc_q   <= '0;
      skid_data_q <= '0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_pc_q   <= main_pc_d;
      main_data_q <= main_data_d;
      skid_pc_q   <= skid_pc_d;
      skid_data_q <= skid_data_d;
      in_ready_q  <= in_ready_d;
    end
  end

`ifdef PIPE_SKID_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Saturating; only reset clears it, flush leaves it alone.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid_o && !out_ready_i && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_pipe_skid_reg;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned PC_W   = 16;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_i = 1'b1, flush_i = 1'b0, in_valid_i = 1'b0, out_ready_i = 1'b0;
  logic [PC_W-1:0]   pc_i = '0;
  logic [DATA_W-1:0] data_i = '0;
  logic              in_ready_o, out_valid_o;
  logic [PC_W-1:0]   pc_o;
  logic [DATA_W-1:0] data_o;
  logic [1:0]        occ_o;
  logic [CNT_W-1:0]  stall_cnt_o;

  pipe_skid_reg #(.DATA_W(DATA_W), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o), .pc_i(pc_i), .data_i(data_i), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .pc_o(pc_o), .data_o(data_o), .occ_o(occ_o),
    .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] data;
  } ent_t;

  // Reference model: FIFO of held entries plus the last shown output values.
  ent_t        mq[$];
  ent_t        m_last;
  int unsigned m_cnt;
  bit          chk_en = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    bit in_acc, out_acc, ov;
    ov      = (mq.size() > 0);
    in_acc  = in_valid_i && (mq.size() < 2);
    out_acc = ov && out_ready_i;
    if (rst_i) begin
      mq.delete();
      m_last = '0;
      m_cnt  = 0;
    end else begin
`ifdef PIPE_SKID_STALL_CNT_EN
      if (ov && !out_ready_i && m_cnt < CNT_MAX) m_cnt++;
`endif
      if (flush_i) begin
        mq.delete();
        m_last = '0;
      end else begin
        if (out_acc) m_last = mq.pop_front();
        if (in_acc) mq.push_back('{pc: pc_i, data: data_i});
      end
    end
  end

  // Single compare process: every output against the model each cycle.
  always @(negedge clk) begin
    ent_t shown;
    if (chk_en) begin
      shown = (mq.size() > 0) ? mq[0] : m_last;
      chk("occ", 64'(occ_o), 64'(mq.size()));
      chk("out_valid", 64'(out_valid_o), 64'(mq.size() > 0));
      chk("in_ready", 64'(in_ready_o), 64'(mq.size() < 2));
      chk("pc", 64'(pc_o), 64'(shown.pc));
      chk("data", 64'(data_o), 64'(shown.data));
      chk("stall_cnt", 64'(stall_cnt_o), 64'(m_cnt));
    end
  end

  task automatic cyc(input bit v, input logic [DATA_W-1:0] d, input bit ordy,
                     input bit fl = 1'b0, input bit rs = 1'b0);
    in_valid_i  = v;
    data_i      = d;
    pc_i        = PC_W'(d + 32'h100);
    out_ready_i = ordy;
    flush_i     = fl;
    rst_i       = rs;
    @(negedge clk);
  endtask

  initial begin
    int unsigned exp_stall;
    @(posedge clk);
    #1 chk_en = 1'b1;
    @(negedge clk);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0);
    // Reset values
    chk("rst_occ", 64'(occ_o), 64'd0);
    chk("rst_in_ready", 64'(in_ready_o), 64'd1);
    chk("rst_out_valid", 64'(out_valid_o), 64'd0);
    chk("rst_data", 64'(data_o), 64'd0);
    chk("rst_stall", 64'(stall_cnt_o), 64'd0);

    // Streaming 1..4
    for (int k = 1; k <= 4; k++) begin
      cyc(1, DATA_W'(k), 1);
      chk("stream_data", 64'(data_o), 64'(k));
      chk("stream_occ", 64'(occ_o), 64'd1);
    end
    cyc(0, 0, 1);
    chk("drain_occ", 64'(occ_o), 64'd0);
    chk("drain_hold", 64'(data_o), 64'd4);

    // Back-pressure
    cyc(1, 32'hA, 0);
    cyc(1, 32'hB, 0);
    chk("bp_occ", 64'(occ_o), 64'd2);
    chk("bp_in_ready", 64'(in_ready_o), 64'd0);
    chk("bp_data", 64'(data_o), 64'hA);
    cyc(0, 0, 1);
    chk("bp_second", 64'(data_o), 64'hB);
    cyc(0, 0, 1);
    chk("bp_empty", 64'(out_valid_o), 64'd0);

    // Flush in TWO with an offered input
    cyc(1, 32'h1, 0);
    cyc(1, 32'h2, 0);
    cyc(1, 32'hC, 0, 1);
    chk("fl_valid", 64'(out_valid_o), 64'd0);
    chk("fl_data", 64'(data_o), 64'd0);
    chk("fl_occ", 64'(occ_o), 64'd0);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 1);
      chk("fl_no_c", 64'(out_valid_o), 64'd0);
    end

    // Reset beats flush
    cyc(1, 32'h5, 0);
    cyc(0, 0, 0, 1, 1);
    chk("rf_occ", 64'(occ_o), 64'd0);
    chk("rf_in_ready", 64'(in_ready_o), 64'd1);
    chk("rf_data", 64'(data_o), 64'd0);
    chk("rf_stall", 64'(stall_cnt_o), 64'd0);

    // Stall counter: 20 back-pressured cycles
    cyc(1, 32'h7, 0);
    for (int k = 0; k < 20; k++) cyc(0, 0, 0);
`ifdef PIPE_SKID_STALL_CNT_EN
    exp_stall = 15;
`else
    exp_stall = 0;
`endif
    chk("stall_sat", 64'(stall_cnt_o), 64'(exp_stall));
    cyc(0, 0, 0, 1);
    chk("stall_after_flush", 64'(stall_cnt_o), 64'(exp_stall));

    // Randomized traffic, occasional flush and reset
    for (int k = 0; k < 4000; k++) begin
      cyc(1'($urandom_range(0, 3) != 0), $urandom(), 1'($urandom_range(0, 2) != 0),
          1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 399) == 0));
    end
    cyc(0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
